// File: rtl/glb_ring_end.sv
// glb_ring_end: terminates the processor/config rings at the east end.
// Reads return UNMAPPED_DATA after RD_LAT cycles, writes are dropped, and the
// stream return is tied to zero.
// Optional build macro GLB_RING_END_ERR_CNT_EN adds saturating error counters
// and a one-shot error interrupt; without it those outputs are tied to zero.
module glb_ring_end #(
  parameter int unsigned       NUM_CH        = 4,
  parameter int unsigned       ADDR_W        = 22,
  parameter int unsigned       DATA_W        = 64,
  parameter int unsigned       RD_LAT        = 2,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = '1,
  parameter int unsigned       STRM_W        = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        proc_wr_en_w2e_wsti,
  input  logic [NUM_CH-1:0]        proc_rd_en_w2e_wsti,
  input  logic [NUM_CH*ADDR_W-1:0] proc_rd_addr_w2e_wsti,
  output logic [NUM_CH*DATA_W-1:0] proc_rd_data_e2w_wsto,
  output logic [NUM_CH-1:0]        proc_rd_data_valid_e2w_wsto,
  output logic [STRM_W-1:0]        strm_packet_e2w_wsto,
  input  logic                     cfg_rd_en_wsti,
  input  logic                     cfg_wr_en_wsti,
  output logic [31:0]              cfg_rd_data_wsto,
  output logic                     cfg_rd_data_valid_wsto,
  input  logic                     err_clr,
  output logic [15:0]              err_wr_cnt,
  output logic [15:0]              err_rd_cnt,
  output logic                     err_irq
);

  localparam int unsigned CFG_W = 32;
  localparam int unsigned CNT_W = 16;

  logic [NUM_CH-1:0]        vld_next_c;
  logic [NUM_CH-1:0]        rd_vld_q;
  logic [NUM_CH*DATA_W-1:0] rd_data_q;
  logic                     cfg_vld_q;
  logic [CFG_W-1:0]         cfg_data_q;

  // Address and config writes carry no information at the ring end.
  logic unused_inputs;
  assign unused_inputs = ^{proc_rd_addr_w2e_wsti, cfg_wr_en_wsti};

  // Delay line for read requests; vld_next_c is the valid due next cycle.
  if (RD_LAT == 1) begin : g_lat1
    assign vld_next_c = proc_rd_en_w2e_wsti;
  end else begin : g_latn
    logic [NUM_CH-1:0] stage_q [RD_LAT-1];

    // Shift requests through RD_LAT-1 stages before the output flop.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < int'(RD_LAT) - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= proc_rd_en_w2e_wsti;
        for (int i = 1; i < int'(RD_LAT) - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign vld_next_c = stage_q[RD_LAT-2];
  end

  // Registered read return: valid plus UNMAPPED_DATA, zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= vld_next_c;
      for (int ch = 0; ch < int'(NUM_CH); ch++) begin
        rd_data_q[ch*DATA_W +: DATA_W] <= vld_next_c[ch] ? UNMAPPED_DATA : '0;
      end
    end
  end

  // Config read return one cycle after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_vld_q  <= 1'b0;
      cfg_data_q <= '0;
    end else begin
      cfg_vld_q  <= cfg_rd_en_wsti;
      cfg_data_q <= cfg_rd_en_wsti ? CFG_W'(UNMAPPED_DATA) : '0;
    end
  end

  assign proc_rd_data_valid_e2w_wsto = rd_vld_q;
  assign proc_rd_data_e2w_wsto       = rd_data_q;
  assign cfg_rd_data_valid_wsto      = cfg_vld_q;
  assign cfg_rd_data_wsto            = cfg_data_q;
  assign strm_packet_e2w_wsto        = '0;

`ifdef GLB_RING_END_ERR_CNT_EN
  typedef enum logic {ST_IDLE, ST_ERR} err_state_e;

  err_state_e       state_q, state_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [31:0]      wr_inc_c, rd_inc_c;
  logic             event_c;

  function automatic logic [31:0] popcount(input logic [NUM_CH-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < int'(NUM_CH); i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Adds without wrapping; anything past the top clamps to all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [31:0] inc);
    logic [32:0] s;
    s = 33'(a) + 33'(inc);
    return (s > 33'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(s);
  endfunction

  assign wr_inc_c = popcount(proc_wr_en_w2e_wsti);
  assign rd_inc_c = popcount(proc_rd_en_w2e_wsti) + 32'(cfg_rd_en_wsti);
  assign event_c  = (|proc_wr_en_w2e_wsti) | (|proc_rd_en_w2e_wsti) | cfg_rd_en_wsti;

  // Next-state for counters and error FSM; a clear overrides same-cycle events.
  always_comb begin
    state_d  = state_q;
    irq_d    = 1'b0;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (err_clr) begin
      state_d  = ST_IDLE;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      wr_cnt_d = sat_add(wr_cnt_q, wr_inc_c);
      rd_cnt_d = sat_add(rd_cnt_q, rd_inc_c);
      case (state_q)
        ST_IDLE: begin
          if (event_c) begin
            state_d = ST_ERR;
            irq_d   = 1'b1;
          end
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Error state, counter and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign err_wr_cnt = wr_cnt_q;
  assign err_rd_cnt = rd_cnt_q;
  assign err_irq    = irq_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  assign err_wr_cnt = '0;
  assign err_rd_cnt = '0;
  assign err_irq    = 1'b0;
`endif

endmodule
